hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit consuming the register-file read operands (RsData/RtData) in EX.
//   Implements MULT/MULTU (and DIV/DIVU when enabled) one bit per cycle into HI/LO registers;
//   HiOut/LoOut feed the MFHI/MFLO writeback mux back into the register file.
// PARAMETERS
//   WIDTH   32   operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//   clk     in   1      single clock, posedge
//   rst     in   1      synchronous reset, active-high
//   Start   in   1      request; sampled at posedge, accepted only in IDLE or DONE
//   Op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (latched on accept)
//   Src1    in   WIDTH  Rs operand (multiplicand / dividend)
//   Src2    in   WIDTH  Rt operand (multiplier / divisor)
//   Busy    out  1      high while iterating
//   Done    out  1      one-cycle pulse; HiOut/LoOut valid with new result in that cycle
//   HiOut   out  WIDTH  HI register (mult: upper product; div: remainder)
//   LoOut   out  WIDTH  LO register (mult: lower product; div: quotient)
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=IDLE, Busy=0, Done=0, HiOut=0, LoOut=0, counter=0. Reset
//   wins over all else; reset mid-operation discards work, HI/LO cleared.
// - FSM: IDLE -(Start & legal Op)-> RUN; RUN -(counter==WIDTH-1)-> DONE;
//   DONE -(Start & legal Op)-> RUN, else -> IDLE.
// - Accept: Op, Src1, Src2 latched at accepting edge; signed ops latch magnitudes plus result-sign
//   flags. Src1/Src2 may change freely afterwards.
// - Latency: accept at edge N; Busy=1 for cycles N+1..N+WIDTH; HI/LO written at edge N+WIDTH+1;
//   Done=1 during cycle N+WIDTH+1 only (start->Done = WIDTH+1 = 33 cycles).
// - Start while Busy: ignored, no effect on the running op. Back-to-back: Start in the DONE cycle
//   is accepted; Busy rises next cycle.
// - HI/LO hold their values between operations; they change only at completion or reset.
// - Multiply: shift-add over 2*WIDTH accumulator; MULT result = two's-complement 64-bit product;
//   MULTU unsigned. Example: 0x80000000*0x80000000 signed -> HI=0x40000000, LO=0.
// - Divide (restoring, 1 quotient bit/cycle): quotient truncates toward zero; remainder takes
//   the dividend's sign; DIV 0x80000000/-1 -> LO=0x80000000, HI=0 (no trap).
// - Divide by zero: HI=Src1 as latched (original value), LO=all ones; same latency, Done
//   pulses normally.
// - Op change or Src change during RUN: no effect.
// CONFIGURATION
//   HILO_DIV_EN defined: Op 10/11 perform DIV/DIVU as above.
//   HILO_DIV_EN undefined: divider datapath absent; Start with Op[1]=1 ignored (stays IDLE/DONE->IDLE,
//   Busy=0, no Done, HI/LO unchanged); MULT/MULTU unaffected.
// TESTING
// 1 MULTU 0xFFFFFFFF*0xFFFFFFFF -> Done at cycle 33, HI=0xFFFFFFFE, LO=0x00000001, Busy 32 cycles.
// 2 MULT -3 (0xFFFFFFFD) * 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MULT 0*x -> HI=LO=0.
// 3 [DIV_EN] DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/0 -> HI=0x64, LO=0xFFFFFFFF.
// 4 Start MULTU 5*6, reassert Start with other operands at cycle 10 -> ignored; result HI=0, LO=30.
// 5 Start in Done cycle (MULTU 2*3 then 4*5) -> Busy next cycle, second Done 33 cycles later, LO=20.
// 6 rst at cycle 15 of MULT -> next cycle Busy=0, Done=0, HI=LO=0, no Done pulse; [no DIV_EN]
//   Start with Op=10 -> Busy stays 0.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
//   Iterative multiply/divide unit for the EX stage. Takes the register-file
//   read operands and produces a HI/LO pair, one bit per clock:
//     - MULT/MULTU : shift-add over a 2*WIDTH accumulator.
//     - DIV/DIVU   : restoring division (only when HILO_DIV_EN is defined).
//   Signed operations run on operand magnitudes. The result signs are
//   captured when the request is accepted and applied on the final
//   iteration.
//
// Configuration macro:
//   HILO_DIV_EN  defined   -> Op 10/11 perform DIV/DIVU.
//                undefined -> no divider datapath. A Start with Op[1]=1 is
//                             ignored and MULT/MULTU behave as normal.
//
// Ports:
//   clk     in   1      clock, rising edge
//   rst     in   1      synchronous reset, active-high
//   Start   in   1      request; accepted only in IDLE or DONE
//   Op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   Src1    in   WIDTH  multiplicand / dividend
//   Src2    in   WIDTH  multiplier / divisor
//   Busy    out  1      high while iterating
//   Done    out  1      one-cycle pulse; HiOut/LoOut carry the new result
//   HiOut   out  WIDTH  HI (upper product / remainder)
//   LoOut   out  WIDTH  LO (lower product / quotient)
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] Src1,
    input  logic [WIDTH-1:0] Src2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;   // partial product hi / partial remainder
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;   // multiplier+product lo / dividend+quotient
    logic [WIDTH-1:0]   opb_q, opb_d;         // multiplicand or divisor magnitude
    logic               neg_res_q, neg_res_d; // negate product / quotient
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
`ifdef HILO_DIV_EN
    logic               is_div_q, is_div_d;
    logic               neg_rem_q, neg_rem_d; // remainder follows the dividend's sign
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   src1_q, src1_d;       // original dividend for divide-by-zero
`endif

    // Operand magnitudes (signed ops only; Op[0]=0 means signed).
    logic             signed_op;
    logic             src1_neg, src2_neg;
    logic [WIDTH-1:0] mag1, mag2;
    logic             op_legal;

    always_comb begin
        signed_op = ~Op[0];
        src1_neg  = signed_op & Src1[WIDTH-1];
        src2_neg  = signed_op & Src2[WIDTH-1];
        mag1      = src1_neg ? (~Src1 + 1'b1) : Src1;
        mag2      = src2_neg ? (~Src2 + 1'b1) : Src2;
`ifdef HILO_DIV_EN
        op_legal  = 1'b1;
`else
        op_legal  = ~Op[1];
`endif
    end

    // One iteration step for each datapath.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx;
    logic [2*WIDTH-1:0] mul_prod, mul_res;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        mul_prod  = {mul_hi_nx, mul_lo_nx};
        mul_res   = neg_res_q ? (~mul_prod + 1'b1) : mul_prod;
    end

`ifdef HILO_DIV_EN
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_hi_nx, div_lo_nx;
    logic [WIDTH-1:0]   div_quo, div_rem;

    always_comb begin
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = (div_shift >= {1'b0, opb_q});
        // The partial remainder stays below the divisor, so after the
        // optional subtract the value always fits in WIDTH bits.
        div_hi_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo_nx = {acc_lo_q[WIDTH-2:0], div_ge};
        div_quo   = neg_res_q ? (~div_lo_nx + 1'b1) : div_lo_nx;
        div_rem   = neg_rem_q ? (~div_hi_nx + 1'b1) : div_hi_nx;
    end
`endif

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef HILO_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        src1_d    = src1_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (Start && op_legal) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    acc_hi_d  = '0;
                    neg_res_d = src1_neg ^ src2_neg;
                    acc_lo_d  = mag2;   // multiplier is shifted out of LO
                    opb_d     = mag1;
`ifdef HILO_DIV_EN
                    is_div_d  = Op[1];
                    neg_rem_d = src1_neg;
                    dbz_d     = (Src2 == '0);
                    src1_d    = Src1;
                    if (Op[1]) begin
                        acc_lo_d = mag1;   // dividend is shifted out of LO
                        opb_d    = mag2;
                    end
`endif
                end
            end
            S_RUN: begin
                cnt_d    = cnt_q + 1'b1;
                acc_hi_d = mul_hi_nx;
                acc_lo_d = mul_lo_nx;
`ifdef HILO_DIV_EN
                if (is_div_q) begin
                    acc_hi_d = div_hi_nx;
                    acc_lo_d = div_lo_nx;
                end
`endif
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    hi_d    = mul_res[2*WIDTH-1:WIDTH];
                    lo_d    = mul_res[WIDTH-1:0];
`ifdef HILO_DIV_EN
                    if (is_div_q) begin
                        if (dbz_q) begin
                            hi_d = src1_q;
                            lo_d = '1;
                        end else begin
                            hi_d = div_rem;
                            lo_d = div_quo;
                        end
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef HILO_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            src1_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef HILO_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            src1_q    <= src1_d;
`endif
        end
    end

    assign Busy  = (state_q == S_RUN);
    assign Done  = (state_q == S_DONE);
    assign HiOut = hi_q;
    assign LoOut = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed testbench for hilo_muldiv_unit (WIDTH=32). The divide tests are
// built only when HILO_DIV_EN is defined. Otherwise the bench checks that
// divide requests are ignored.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] Src1 = '0;
    logic [31:0] Src2 = '0;
    logic        Busy, Done;
    logic [31:0] HiOut, LoOut;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .Op    (Op),
        .Src1  (Src1),
        .Src2  (Src2),
        .Busy  (Busy),
        .Done  (Done),
        .HiOut (HiOut),
        .LoOut (LoOut)
    );

    // Call at a negedge. Start is high across exactly one posedge, and the
    // task returns at the negedge of the first cycle after acceptance.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; Op = op; Src1 = a; Src2 = b;
        @(negedge clk);
        Start = 1'b0; Src1 = 32'hDEAD_BEEF; Src2 = 32'hCAFE_F00D; Op = ~op;
    endtask

    // Waits for Done. cyc counts cycles since acceptance, and busy counts the
    // Busy cycles observed while waiting. The wait is bounded.
    task automatic wait_done(input int start_cyc, output int cyc, output int busy, output bit seen);
        cyc = start_cyc; busy = 0; seen = 1'b0;
        while (cyc < 100) begin
            if (Done) begin
                seen = 1'b1;
                break;
            end
            if (Busy) busy++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (Busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        n_checks++; if (Done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", Done); end
        n_checks++; if (HiOut !== 32'h0) begin n_errors++; $display("FAIL reset_hi: got %h expected 00000000", HiOut); end
        n_checks++; if (LoOut !== 32'h0) begin n_errors++; $display("FAIL reset_lo: got %h expected 00000000", LoOut); end
        $display("reset: Busy=%b Done=%b HI=%h LO=%h", Busy, Done, HiOut, LoOut);
    endtask

    task automatic test_multu_max();
        int cyc, busy; bit seen;
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++; if (Busy !== 1'b1) begin n_errors++; $display("FAIL multu_busy_rise: got %b expected 1", Busy); end
        wait_done(1, cyc, busy, seen);
        n_checks++; if (!seen) begin n_errors++; $display("FAIL multu_timeout: got no Done expected Done"); end
        n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL multu_latency: got %0d expected 33", cyc); end
        n_checks++; if (busy !== 32) begin n_errors++; $display("FAIL multu_busy_cycles: got %0d expected 32", busy); end
        n_checks++; if (HiOut !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL multu_hi: got %h expected fffffffe", HiOut); end
        n_checks++; if (LoOut !== 32'h0000_0001) begin n_errors++; $display("FAIL multu_lo: got %h expected 00000001", LoOut); end
        $display("MULTU ffffffff*ffffffff: cyc=%0d busy=%0d HI=%h LO=%h", cyc, busy, HiOut, LoOut);
        @(negedge clk);
        n_checks++; if (Done !== 1'b0) begin n_errors++; $display("FAIL done_pulse_width: got %b expected 0", Done); end
        repeat (5) @(negedge clk);
        n_checks++; if (HiOut !== 32'hFFFF_FFFE || LoOut !== 32'h1) begin
            n_errors++; $display("FAIL hilo_hold: got %h_%h expected fffffffe_00000001", HiOut, LoOut);
        end
    endtask

    task automatic test_mult_signed();
        int cyc, busy; bit seen;
        logic [31:0] a [3] = '{32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000};
        logic [31:0] b [3] = '{32'h0000_0007, 32'h1234_5678, 32'h8000_0000};
        logic [31:0] eh[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h4000_0000};
        logic [31:0] el[3] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            start_op(2'b00, a[i], b[i]);
            wait_done(1, cyc, busy, seen);
            n_checks++; if (!seen || cyc !== 33) begin n_errors++; $display("FAIL mult_latency[%0d]: got %0d expected 33", i, cyc); end
            n_checks++; if (HiOut !== eh[i]) begin n_errors++; $display("FAIL mult_hi[%0d]: got %h expected %h", i, HiOut, eh[i]); end
            n_checks++; if (LoOut !== el[i]) begin n_errors++; $display("FAIL mult_lo[%0d]: got %h expected %h", i, LoOut, el[i]); end
            $display("MULT %h*%h: HI=%h LO=%h", a[i], b[i], HiOut, LoOut);
            @(negedge clk);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc, busy; bit seen;
        start_op(2'b01, 32'd5, 32'd6);
        repeat (8) @(negedge clk);          // now in cycle 9 after acceptance
        Start = 1'b1; Op = 2'b00; Src1 = 32'd99; Src2 = 32'd77;
        @(negedge clk);                      // cycle 10
        Start = 1'b0;
        n_checks++; if (Busy !== 1'b1) begin n_errors++; $display("FAIL ignore_busy: got %b expected 1", Busy); end
        wait_done(10, cyc, busy, seen);
        n_checks++; if (!seen || cyc !== 33) begin n_errors++; $display("FAIL ignore_latency: got %0d expected 33", cyc); end
        n_checks++; if (HiOut !== 32'h0 || LoOut !== 32'd30) begin
            n_errors++; $display("FAIL ignore_result: got %h_%h expected 00000000_0000001e", HiOut, LoOut);
        end
        $display("MULTU 5*6 with restart while busy: cyc=%0d HI=%h LO=%h", cyc, HiOut, LoOut);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, busy; bit seen;
        start_op(2'b01, 32'd2, 32'd3);
        wait_done(1, cyc, busy, seen);
        n_checks++; if (!seen || LoOut !== 32'd6) begin n_errors++; $display("FAIL b2b_first: got %h expected 00000006", LoOut); end
        start_op(2'b01, 32'd4, 32'd5);       // issued during the Done cycle
        n_checks++; if (Busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy: got %b expected 1", Busy); end
        wait_done(1, cyc, busy, seen);
        n_checks++; if (!seen || cyc !== 33) begin n_errors++; $display("FAIL b2b_latency: got %0d expected 33", cyc); end
        n_checks++; if (HiOut !== 32'h0 || LoOut !== 32'd20) begin
            n_errors++; $display("FAIL b2b_result: got %h_%h expected 00000000_00000014", HiOut, LoOut);
        end
        $display("MULTU 2*3 then 4*5 back-to-back: cyc=%0d HI=%h LO=%h", cyc, HiOut, LoOut);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        start_op(2'b00, 32'h0001_2345, 32'h0000_0010);
        repeat (14) @(negedge clk);          // cycle 15
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin n_errors++; $display("FAIL rstmid_ctrl: got Busy=%b Done=%b expected 0 0", Busy, Done); end
        n_checks++; if (HiOut !== 32'h0 || LoOut !== 32'h0) begin n_errors++; $display("FAIL rstmid_hilo: got %h_%h expected 0_0", HiOut, LoOut); end
        for (int i = 0; i < 40; i++) begin
            if (Done) saw_done = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (saw_done !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_done: got Done pulse expected none"); end
        $display("reset mid-MULT: Busy=%b HI=%h LO=%h", Busy, HiOut, LoOut);
    endtask

`ifdef HILO_DIV_EN
    task automatic test_div();
        int cyc, busy; bit seen;
        logic [1:0]  o [4] = '{2'b10, 2'b11, 2'b10, 2'b10};
        logic [31:0] a [4] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7};
        logic [31:0] b [4] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] eh[4] = '{32'hFFFF_FFFF, 32'h0000_0064, 32'h0, 32'h1};
        logic [31:0] el[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD};
        for (int i = 0; i < 4; i++) begin
            start_op(o[i], a[i], b[i]);
            wait_done(1, cyc, busy, seen);
            n_checks++; if (!seen || cyc !== 33) begin n_errors++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, cyc); end
            n_checks++; if (HiOut !== eh[i]) begin n_errors++; $display("FAIL div_hi[%0d]: got %h expected %h", i, HiOut, eh[i]); end
            n_checks++; if (LoOut !== el[i]) begin n_errors++; $display("FAIL div_lo[%0d]: got %h expected %h", i, LoOut, el[i]); end
            $display("DIV op=%b %h/%h: HI=%h LO=%h", o[i], a[i], b[i], HiOut, LoOut);
            @(negedge clk);
        end
    endtask
`else
    task automatic test_div_disabled();
        int cyc, busy; bit seen;
        bit saw = 1'b0;
        start_op(2'b01, 32'd9, 32'd9);
        wait_done(1, cyc, busy, seen);
        start_op(2'b11, 32'd100, 32'd7);    // DIVU issued in the Done cycle
        n_checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin n_errors++; $display("FAIL nodiv_from_done: got Busy=%b Done=%b expected 0 0", Busy, Done); end
        start_op(2'b10, 32'd100, 32'd7);    // DIV issued from IDLE
        for (int i = 0; i < 40; i++) begin
            if (Busy || Done) saw = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (saw !== 1'b0) begin n_errors++; $display("FAIL nodiv_activity: got Busy/Done activity expected none"); end
        n_checks++; if (HiOut !== 32'h0 || LoOut !== 32'd81) begin
            n_errors++; $display("FAIL nodiv_hilo: got %h_%h expected 00000000_00000051", HiOut, LoOut);
        end
        $display("DIV without divider: Busy=%b HI=%h LO=%h", Busy, HiOut, LoOut);
    endtask
`endif

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef HILO_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
